// File: rtl/car_motion_controller_if.sv
// car_motion_controller_if: player-control and car-state bundle between the
// frame logic and its environment (controls, hvsync generator, renderer).
//   vsync      : vertical sync level from the hvsync generator
//   btn_*      : steering / throttle levels
//   collision  : car/obstacle pixel overlap flag from the renderer
//   player_x/y : car sprite position for the renderer
//   speed      : current speed for road scrolling
//   odometer   : accumulated distance
//   crashed    : high while in the crash/recovery state
//   frame_tick : one-cycle pulse after each frame update
interface car_motion_controller_if;
    logic        vsync;
    logic        btn_left;
    logic        btn_right;
    logic        btn_up;
    logic        btn_down;
    logic        collision;
    logic [8:0]  player_x;
    logic [8:0]  player_y;
    logic [3:0]  speed;
    logic [15:0] odometer;
    logic        crashed;
    logic        frame_tick;

    // Controller side.
    modport slave (
        input  vsync, btn_left, btn_right, btn_up, btn_down, collision,
        output player_x, player_y, speed, odometer, crashed, frame_tick
    );

    // Environment side.
    modport master (
        output vsync, btn_left, btn_right, btn_up, btn_down, collision,
        input  player_x, player_y, speed, odometer, crashed, frame_tick
    );
endinterface

// File: rtl/car_motion_controller.sv
// car_motion_controller: per-frame player-car state generator upstream of the
// sprite renderer. On each vsync rising edge it updates position, speed and
// odometer from the controls and runs a DRIVE/CRASH recovery FSM driven by
// the renderer's collision flag.
//   clk   : system pixel clock
//   reset : synchronous, active-high
//   bus   : car_motion_controller_if.slave (controls in, car state out)
module car_motion_controller #(
    parameter logic [8:0] START_X      = 9'd128,
    parameter logic [8:0] START_Y      = 9'd128,
    parameter logic [8:0] X_MIN        = 9'd16,
    parameter logic [8:0] X_MAX        = 9'd232,
    parameter logic [3:0] MAX_SPEED    = 4'd7,
    parameter logic [7:0] CRASH_FRAMES = 8'd30
) (
    input  logic                    clk,
    input  logic                    reset,
    car_motion_controller_if.slave  bus
);

    typedef enum logic {
        DRIVE = 1'b0,
        CRASH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_q;
    logic        vs_block_q;
    logic [8:0]  x_q, x_d;
    logic [3:0]  speed_q, speed_d;
    logic [15:0] odo_q, odo_d;
    logic [7:0]  timer_q, timer_d;
    logic        coll_q, coll_d;
    logic        crashed_q, crashed_d;
    logic        frame_tick_q, frame_tick_d;
    logic        tick;
    logic        hit;

    // vs_block_q suppresses the edge detector when vsync is still high from
    // before reset was released, so only a fresh rise counts as a frame.
    assign tick = bus.vsync & ~vsync_q & ~vs_block_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        speed_d      = speed_q;
        odo_d        = odo_q;
        timer_d      = timer_q;
        coll_d       = coll_q;
        frame_tick_d = 1'b0;
        hit          = coll_q | bus.collision;

        if (state_q == DRIVE) begin
            if (bus.collision) begin
                coll_d = 1'b1;
            end
        end else begin
            coll_d = 1'b0;
        end

        if (tick) begin
            frame_tick_d = 1'b1;
            coll_d       = 1'b0;
            case (state_q)
                DRIVE: begin
                    if (hit) begin
                        state_d = CRASH;
                        timer_d = CRASH_FRAMES;
                        speed_d = '0;
                    end else begin
                        // Distance uses the speed held during the frame just ended.
                        odo_d = odo_q + {12'd0, speed_q};

                        if (bus.btn_up && !bus.btn_down) begin
                            speed_d = (speed_q < MAX_SPEED) ? speed_q + 4'd1 : MAX_SPEED;
                        end else if (bus.btn_down && !bus.btn_up) begin
                            speed_d = (speed_q != 4'd0) ? speed_q - 4'd1 : 4'd0;
                        end

                        if (bus.btn_left && !bus.btn_right) begin
                            x_d = (x_q > X_MIN) ? x_q - 9'd1 : X_MIN;
                        end else if (bus.btn_right && !bus.btn_left) begin
                            x_d = (x_q < X_MAX) ? x_q + 9'd1 : X_MAX;
                        end
                    end
                end
                CRASH: begin
                    speed_d = '0;
                    if (timer_q == 8'd1) begin
                        state_d = DRIVE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                default: state_d = DRIVE;
            endcase
        end

        crashed_d = (state_d == CRASH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DRIVE;
            vsync_q      <= 1'b0;
            vs_block_q   <= bus.vsync;
            x_q          <= START_X;
            speed_q      <= '0;
            odo_q        <= '0;
            timer_q      <= '0;
            coll_q       <= 1'b0;
            crashed_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus.vsync;
            vs_block_q   <= vs_block_q & bus.vsync;
            x_q          <= x_d;
            speed_q      <= speed_d;
            odo_q        <= odo_d;
            timer_q      <= timer_d;
            coll_q       <= coll_d;
            crashed_q    <= crashed_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.player_x   = x_q;
    assign bus.player_y   = START_Y;
    assign bus.speed      = speed_q;
    assign bus.odometer   = odo_q;
    assign bus.crashed    = crashed_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_car_motion_controller.sv
module tb_car_motion_controller;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    car_motion_controller_if bus ();

    car_motion_controller #(
        .START_X      (9'd128),
        .START_Y      (9'd128),
        .X_MIN        (9'd16),
        .X_MAX        (9'd232),
        .MAX_SPEED    (4'd7),
        .CRASH_FRAMES (8'd30)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state of the car
    logic [8:0]  m_x;
    logic [3:0]  m_speed;
    logic [15:0] m_odo;
    bit          m_crash;
    bit          m_latch;
    int          m_timer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 9'd128; m_speed = 4'd0; m_odo = 16'd0;
        m_crash = 0; m_latch = 0; m_timer = 0;
    endtask

    task automatic model_tick(input logic up, dn, lf, rt, coll);
        bit h;
        h = m_latch | coll;
        m_latch = 0;
        if (!m_crash) begin
            if (h) begin
                m_crash = 1; m_timer = 30; m_speed = 4'd0;
            end else begin
                m_odo = m_odo + 16'(m_speed);
                if (up && !dn && m_speed != 4'd7) m_speed = m_speed + 4'd1;
                if (dn && !up && m_speed != 4'd0) m_speed = m_speed - 4'd1;
                if (lf && !rt && m_x != 9'd16)  m_x = m_x - 9'd1;
                if (rt && !lf && m_x != 9'd232) m_x = m_x + 9'd1;
            end
        end else begin
            m_speed = 4'd0;
            if (m_timer == 1) begin m_crash = 0; m_timer = 0; end
            else m_timer = m_timer - 1;
        end
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, "_player_x"}, 32'(bus.player_x), 32'(m_x));
        chk({pfx, "_player_y"}, 32'(bus.player_y), 32'd128);
        chk({pfx, "_speed"},    32'(bus.speed),    32'(m_speed));
        chk({pfx, "_odometer"}, 32'(bus.odometer), 32'(m_odo));
        chk({pfx, "_crashed"},  32'(bus.crashed),  32'(m_crash));
    endtask

    // One frame: vsync rises with the given controls, then falls.
    task automatic frame(input logic up, dn, lf, rt, coll);
        @(negedge clk);
        bus.btn_up = up; bus.btn_down = dn; bus.btn_left = lf; bus.btn_right = rt;
        bus.collision = coll;
        bus.vsync = 1'b1;
        @(posedge clk); #1;
        bus.collision = 1'b0;
        model_tick(up, dn, lf, rt, coll);
        chk("frame_tick_high", 32'(bus.frame_tick), 32'd1);
        check_state("frame");
        @(negedge clk);
        bus.vsync = 1'b0;
        @(posedge clk); #1;
        chk("frame_tick_low", 32'(bus.frame_tick), 32'd0);
    endtask

    // One-cycle collision pulse between vsync rises.
    task automatic coll_pulse();
        @(negedge clk);
        bus.collision = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0;
        if (!m_crash) m_latch = 1;
    endtask

    initial begin
        logic [15:0] odo_before;
        logic [15:0] odo_pre;
        n_cmp = 0; n_err = 0;
        bus.vsync = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_up = 0; bus.btn_down = 0; bus.collision = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_state("reset");
        chk("reset_frame_tick", 32'(bus.frame_tick), 32'd0);

        // Idle frames
        for (int i = 0; i < 3; i++) frame(0, 0, 0, 0, 0);
        chk("idle_x", 32'(bus.player_x), 32'd128);

        // Accelerate 10 frames: 1..7 then saturate; odometer 42
        for (int i = 1; i <= 10; i++) begin
            frame(1, 0, 0, 0, 0);
            chk("accel_speed", 32'(bus.speed), (i < 7) ? i : 7);
        end
        chk("accel_odo_42", 32'(bus.odometer), 32'd42);

        // Steer left into X_MIN
        for (int i = 1; i <= 150; i++) begin
            frame(0, 0, 1, 0, 0);
            if (i == 111) chk("x_at_111", 32'(bus.player_x), 32'd17);
            if (i == 112) chk("x_at_112", 32'(bus.player_x), 32'd16);
        end
        chk("x_left_hold", 32'(bus.player_x), 32'd16);

        // Steer right into X_MAX
        for (int i = 0; i < 300; i++) frame(0, 0, 0, 1, 0);
        chk("x_right_hold", 32'(bus.player_x), 32'd232);

        // Both steering buttons: no change; both speed buttons: no change
        for (int i = 0; i < 5; i++) frame(1, 1, 1, 1, 0);
        chk("x_both", 32'(bus.player_x), 32'd232);
        chk("speed_both", 32'(bus.speed), 32'd7);

        // Brake to 5
        frame(0, 1, 0, 0, 0);
        frame(0, 1, 0, 0, 0);
        chk("speed_5", 32'(bus.speed), 32'd5);

        // Mid-frame collision pulse, crash on next tick
        odo_before = bus.odometer + 16'd5;
        coll_pulse();
        frame(1, 0, 1, 0, 0);
        chk("crash1_crashed", 32'(bus.crashed), 32'd1);
        chk("crash1_speed", 32'(bus.speed), 32'd0);
        chk("crash1_x", 32'(bus.player_x), 32'd232);
        chk("crash1_odo", 32'(bus.odometer), 32'(odo_before - 16'd5));
        for (int k = 2; k <= 31; k++) begin
            frame(1, 0, 1, 0, 0);
            chk("crash1_len", 32'(bus.crashed), (k <= 30) ? 32'd1 : 32'd0);
            chk("crash1_spd0", 32'(bus.speed), 32'd0);
        end
        frame(1, 0, 0, 0, 0);
        chk("recover_speed1", 32'(bus.speed), 32'd1);

        // Collision on the vsync rise itself; a collision during CRASH is ignored
        frame(0, 0, 0, 0, 1);
        chk("crash2_crashed", 32'(bus.crashed), 32'd1);
        chk("crash2_speed", 32'(bus.speed), 32'd0);
        for (int k = 2; k <= 31; k++) begin
            if (k == 10 || k == 30) coll_pulse();
            frame(0, 0, 0, 0, 0);
            chk("crash2_len", 32'(bus.crashed), (k <= 30) ? 32'd1 : 32'd0);
        end
        frame(0, 0, 0, 0, 0);
        chk("crash2_no_extend", 32'(bus.crashed), 32'd0);

        // Odometer wrap at full speed
        while (m_odo < 16'd65530) frame(1, 0, 0, 0, 0);
        chk("wrap_speed7", 32'(bus.speed), 32'd7);
        odo_pre = bus.odometer;
        frame(1, 0, 0, 0, 0);
        chk("odo_wrap", 32'(bus.odometer), 32'(odo_pre) + 32'd7 - 32'd65536);

        // Reset mid-CRASH with vsync held high through release
        frame(0, 0, 1, 0, 1);
        frame(0, 0, 0, 0, 0);
        chk("pre_reset_crashed", 32'(bus.crashed), 32'd1);
        @(negedge clk);
        bus.vsync = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_state("midcrash_reset");
        chk("midcrash_reset_ft", 32'(bus.frame_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_tick_held_vsync", 32'(bus.frame_tick), 32'd0);
        check_state("held_vsync");
        @(negedge clk);
        bus.vsync = 1'b0;
        @(posedge clk); #1;
        frame(1, 0, 0, 1, 0);
        chk("post_reset_speed", 32'(bus.speed), 32'd1);
        chk("post_reset_x", 32'(bus.player_x), 32'd129);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/car_motion_controller.md
Name: car_motion_controller

Overview:
- Per-frame player-car state generator that sits directly upstream of the sprite renderer.
- Once per frame (vsync rising edge) it samples the player controls, updates horizontal position, speed and odometer, and runs a crash/recovery FSM from the renderer's collision flag.
- player_x/player_y drive the renderer's sprite position compare; speed feeds the road-scroll logic.

Parameters:
- START_X, 128, reset/initial horizontal position (9-bit).
- START_Y, 128, constant vertical position driven on player_y (9-bit).
- X_MIN, 16, leftmost allowed player_x.
- X_MAX, 232, rightmost allowed player_x (X_MIN < X_MAX).
- MAX_SPEED, 7, speed saturation value (fits 4 bits).
- CRASH_FRAMES, 30, frames spent in CRASH (legal range 1..255).

Ports:
- clk  in  1  system pixel clock
- reset  in  1  synchronous, active-high reset
- vsync  in  1  vertical sync from hvsync_generator (level)
- btn_left  in  1  steer left (level)
- btn_right  in  1  steer right (level)
- btn_up  in  1  accelerate (level)
- btn_down  in  1  brake (level)
- collision  in  1  car/obstacle pixel overlap from the renderer (any width pulse)
- player_x  out  9  car sprite left edge
- player_y  out  9  car sprite top edge, constant START_Y
- speed  out  4  current speed, 0..MAX_SPEED
- odometer  out  16  accumulated distance
- crashed  out  1  high while the FSM is in CRASH
- frame_tick  out  1  one-cycle pulse marking a completed frame update

Behaviour:
- Clocking: single clock clk. Reset is synchronous and active-high, named reset. Nothing is clocked by vsync/hsync.
- Reset values: player_x=START_X, speed=0, odometer=0, crashed=0, frame_tick=0, state=DRIVE, crash timer=0, collision latch=0, vsync_q=0.
- Tick detection: vsync_q <= vsync every cycle. tick = vsync & ~vsync_q.
- All frame updates occur on the clk edge where tick=1. frame_tick is registered high for exactly the following cycle; outputs are valid when frame_tick is seen.
- Collision latch: set on any cycle with collision=1 while in DRIVE. Cleared on every tick, after use.
  - Effective hit at a tick = latch | collision (same-cycle collision counts).
  - In CRASH, collision is ignored and the latch stays 0.
- DRIVE, on tick, evaluated in order:
  - Hit: go to CRASH, timer<=CRASH_FRAMES, speed<=0. No steering and no odometer change this frame.
  - Otherwise, odometer <= odometer + speed, using the pre-update speed; 16-bit wrap-around with no saturation.
  - Speed: up only -> min(speed+1, MAX_SPEED); down only -> max(speed-1, 0); both or neither -> unchanged.
  - Steering: left only -> max(player_x-1, X_MIN); right only -> min(player_x+1, X_MAX); both or neither -> unchanged. Clamp compares are unsigned; no wrap below 0.
- CRASH, on tick:
  - Buttons are ignored; speed stays 0; player_x is held.
  - timer==1 -> DRIVE, timer<=0. Otherwise timer<=timer-1.
  - crashed is high for exactly CRASH_FRAMES frame ticks, starting the cycle after the entry tick.
- crashed is a registered decode of state (state==CRASH).
- Between ticks all outputs hold, except frame_tick, which returns to 0.
- Reset mid-CRASH or mid-frame: immediate return to reset values on that edge. A vsync held high through reset release does not generate a tick until it falls and rises again.

Test Plan:
- Reset, then 3 frames with no buttons -> player_x=128, player_y=128, speed=0, odometer=0, crashed=0, one frame_tick per vsync rise.
- btn_up held 10 frames -> speed 1,2,…,7 then stays 7; odometer after 10 ticks = 0+1+…+6+7+7+7 = 42.
- btn_left held 150 frames from 128 -> player_x reaches 16 at tick 112 and holds. btn_right held 300 frames -> 232. Left+right together -> unchanged.
- Speed 5, one-cycle collision pulse mid-frame -> next tick: crashed=1, speed=0, x unchanged. btn_up ignored during crash. crashed stays high for 30 ticks, then drops; next tick with btn_up gives speed=1.
- Collision asserted in the same cycle as the vsync rise -> crash entered on that tick. A collision during CRASH does not extend it.
- Preload odometer near wrap (speed 7, run until odometer ≥ 65530) -> wraps modulo 65536. Reset asserted mid-CRASH -> all outputs return to reset values on the next edge.
